// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM state type, request-size encodings and alignment
// helper for the MEM-stage load/store unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } mau_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int WORD_SHIFT = 2;

    // Reserved size encoding is treated as misaligned so it takes the error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            SIZE_W:  return |off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane extraction for loads and
// lane merge for sub-word stores.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rd,
    input  logic [1:0]       i_off,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_load,
    output logic [WIDTH-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_byte_lsb;
    logic [4:0]  w_half_lsb;

    assign w_byte_lsb = {i_off, 3'b000};
    assign w_half_lsb = {i_off[1], 4'b0000};
    assign w_byte     = i_rd[w_byte_lsb +: 8];
    assign w_half     = i_rd[w_half_lsb +: 16];

    always_comb begin
        o_load   = i_rd;
        o_merged = i_wdata;
        case (i_size)
            SIZE_B: begin
                o_load = i_unsigned ? {{(WIDTH-8){1'b0}}, w_byte}
                                    : {{(WIDTH-8){w_byte[7]}}, w_byte};
                o_merged = i_rd;
                o_merged[w_byte_lsb +: 8] = i_wdata[7:0];
            end
            SIZE_H: begin
                o_load = i_unsigned ? {{(WIDTH-16){1'b0}}, w_half}
                                    : {{(WIDTH-16){w_half[15]}}, w_half};
                o_merged = i_rd;
                o_merged[w_half_lsb +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load   = i_rd;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator driving a word-addressed data
// memory. Sub-word accesses exist only when MEM_ACCESS_SUBWORD_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; memory port quiet, mem_A holds
// ACCESS | memory addressed; load captured, word store written, or RMW word built
// MERGE  | merged sub-word store word written back
// RESP   | one-cycle response strobe
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             stall,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    output logic             mem_WE,
    input  logic [WIDTH-1:0] mem_RD
);

    localparam int               WW      = WIDTH - WORD_SHIFT;
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    mau_state_t       r_state;
    mau_state_t       w_state_nxt;
    logic             r_store;
    logic             r_err;
    logic [WIDTH-1:0] r_mem_a;
    logic [WIDTH-1:0] r_wd;
    logic [WIDTH-1:0] r_rdata;

    logic [WW-1:0]    w_req_word;
    logic             w_accept;
    logic             w_out_of_range;
    logic             w_req_err;
    logic             w_sub;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_merged;

    assign w_req_word     = req_addr[WIDTH-1:WORD_SHIFT];
    assign w_accept       = req_valid && (r_state == ST_IDLE);
    assign w_out_of_range = ({{WORD_SHIFT{1'b0}}, w_req_word} >= DEPTH_W);

`ifdef MEM_ACCESS_SUBWORD_EN
    logic [1:0] r_size;
    logic [1:0] r_off;
    logic       r_unsigned;

    assign w_req_err = is_misaligned(req_size, req_addr[WORD_SHIFT-1:0]) || w_out_of_range;
    assign w_sub     = (r_size != SIZE_W);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_size     <= SIZE_W;
            r_off      <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_size     <= req_size;
            r_off      <= req_addr[WORD_SHIFT-1:0];
            r_unsigned <= req_unsigned;
        end
    end

    mem_lane_align #(
        .WIDTH      (WIDTH)
    ) u_lane_align (
        .i_rd       (mem_RD),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wd),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );
`else
    logic w_unused;

    // Word-only build: anything other than an aligned word is an error.
    assign w_unused  = req_unsigned;
    assign w_req_err = (req_size != SIZE_W) || (|req_addr[WORD_SHIFT-1:0]) || w_out_of_range;
    assign w_sub     = 1'b0;
    assign w_load    = mem_RD;
    assign w_merged  = r_wd;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_we = r_store && !r_err && !w_sub;
                if (r_store && !r_err && w_sub) begin
                    w_state_nxt = ST_MERGE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_MERGE: begin
                w_mem_we    = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // mem_WD carries the raw store data until ACCESS replaces it with the merged word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_store <= 1'b0;
            r_err   <= 1'b0;
            r_mem_a <= '0;
            r_wd    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_store <= req_store;
                r_err   <= w_req_err;
                r_mem_a <= {{WORD_SHIFT{1'b0}}, w_req_word};
                r_wd    <= req_wdata;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= (!r_store && !r_err) ? w_load : '0;
                if (r_store && !r_err && w_sub) begin
                    r_wd <= w_merged;
                end
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign stall     = !req_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = r_rdata;
    assign mem_A     = r_mem_a;
    assign mem_WD    = r_wd;
    assign mem_WE    = w_mem_we;

endmodule
